fixed32_mul: RTL and testbench

//   Pipelined signed fixed-point multiplier for the CORDIC trigonometric datapath.

---
 rtl/fixed_pkg.sv | 21 ++
 rtl/fixed32_round_sat.sv | 41 ++++
 rtl/fixed32_mul.sv | 85 ++++++++
 tb/tb_fixed32_mul.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/fixed_pkg.sv
// Shared Q2.30 fixed-point definitions for the CORDIC gain/scale datapath.
// Contents:
//   q2_30_t     signed 32-bit Q2.30 value (1.0 = 0x40000000, range [-2, 2))
//   FRAC_BITS   number of fractional bits (30)
//   Q_ONE       +1.0
//   Q_MAX       most positive Q2.30 value (2 - 2^-30)
//   Q_MIN       most negative Q2.30 value (-2.0)
//   ROUND_BIAS  half an LSB of the result, expressed in the Q4.60 product
package fixed_pkg;

    localparam int FRAC_BITS = 30;

    typedef logic signed [31:0] q2_30_t;

    localparam q2_30_t Q_ONE = 32'sh40000000;
    localparam q2_30_t Q_MAX = 32'sh7FFFFFFF;
    localparam q2_30_t Q_MIN = 32'sh80000000;

    localparam logic signed [63:0] ROUND_BIAS = 64'sh20000000;

endpackage

// File: rtl/fixed32_round_sat.sv
// Combinational rounding, overflow detection and optional saturation of a
// Q4.60 product down to Q2.30.
// Build option: define FIXED32_MUL_SAT_EN to clamp overflowing results to
// Q_MAX / Q_MIN; otherwise the result wraps (two's complement).
// Ports:
//   product   in   64  signed Q4.60 product
//   result    out  32  rounded Q2.30 result
//   overflow  out  1   rounded product does not fit in Q2.30
module fixed32_round_sat
    import fixed_pkg::*;
(
    input  logic signed [63:0] product,
    output q2_30_t             result,
    output logic               overflow
);

    logic signed [63:0] rounded;
    logic               unused_frac;

    // Adding half an LSB before truncation rounds ties toward +inf.
    assign rounded = product + ROUND_BIAS;

    // The dropped fraction bits carry no information after rounding.
    assign unused_frac = ^rounded[FRAC_BITS-1:0];

    // The shifted value is 34 bits wide; it fits in 32 bits only when the
    // three top bits are a pure sign extension.
    assign overflow = !((rounded[63:61] == 3'b000) || (rounded[63:61] == 3'b111));

`ifdef FIXED32_MUL_SAT_EN
    always_comb begin
        result = rounded[61:30];
        if (overflow) begin
            result = rounded[63] ? Q_MIN : Q_MAX;
        end
    end
`else
    assign result = rounded[61:30];
`endif

endmodule

// File: rtl/fixed32_mul.sv
// Two-stage pipelined signed Q2.30 x Q2.30 multiplier with rounding and
// overflow flag, used for gain/scale correction around the CORDIC core.
// Build option: FIXED32_MUL_SAT_EN (see fixed32_round_sat) selects saturating
// instead of wrapping results; the overflow flag is the same in both builds.
// Ports:
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   a/b valid this cycle
//   a, b       in   32  signed Q2.30 operands
//   out_valid  out  1   result/overflow valid
//   result     out  32  rounded signed Q2.30 product (held during bubbles)
//   overflow   out  1   product outside Q2.30 range (0 during bubbles)
module fixed32_mul
    import fixed_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = 30
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] result,
    output logic                    overflow
);

    generate
        if (WIDTH != 32 || FRAC_BITS != 30) begin : g_bad_cfg
            $error("fixed32_mul supports only WIDTH=32, FRAC_BITS=30");
        end
    endgenerate

    q2_30_t             a_p1;
    q2_30_t             b_p1;
    logic               vld_p1;
    logic signed [63:0] product_p1;
    q2_30_t             rs_result;
    logic               rs_overflow;

    // Stage 1: operand capture. Operands only load on valid input so idle
    // cycles leave the multiplier inputs quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            a_p1   <= '0;
            b_p1   <= '0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                a_p1 <= a;
                b_p1 <= b;
            end
        end
    end

    // Both operands are signed, so the 64-bit context sign-extends them.
    assign product_p1 = a_p1 * b_p1;

    fixed32_round_sat u_round_sat (
        .product  (product_p1),
        .result   (rs_result),
        .overflow (rs_overflow)
    );

    // Stage 2: registered result. Bubbles keep the last result but force
    // overflow low so it never appears without out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
        end else begin
            out_valid <= vld_p1;
            if (vld_p1) begin
                result   <= rs_result;
                overflow <= rs_overflow;
            end else begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fixed32_mul.sv
module tb_fixed32_mul;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic [31:0] result;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          v;
        logic [31:0] r;
        bit          o;
    } exp_t;

    exp_t        prev;
    logic [31:0] held_r;

    always #5 clk = ~clk;

    fixed32_mul dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .result    (result),
        .overflow  (overflow)
    );

    // Reference: exact integer product, round half up to a multiple of 2^-30,
    // then check whether the value fits in the signed 32-bit Q2.30 range.
    function automatic exp_t model(bit v, logic [31:0] x, logic [31:0] y);
        exp_t   e;
        longint p;
        longint q;
        p = longint'($signed(x)) * longint'($signed(y));
        q = (p + (longint'(1) <<< 29)) >>> 30;
        e.v = v;
        e.o = (q > 64'sd2147483647) || (q < -64'sd2147483648);
`ifdef FIXED32_MUL_SAT_EN
        if (e.o) e.r = (q > 0) ? 32'h7FFFFFFF : 32'h80000000;
        else     e.r = 32'(q);
`else
        e.r = 32'(q);
`endif
        return e;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, then check the output produced by the
    // previous step's inputs (two edges after they were applied).
    task automatic step(bit v, logic [31:0] x, logic [31:0] y);
        exp_t cur;
        cur = model(v, x, y);
        @(negedge clk);
        in_valid = v;
        a        = x;
        b        = y;
        @(posedge clk);
        #1;
        chk("out_valid", {31'b0, out_valid}, {31'b0, prev.v});
        if (prev.v) begin
            chk("result", result, prev.r);
            chk("overflow", {31'b0, overflow}, {31'b0, prev.o});
            held_r = prev.r;
        end else begin
            chk("result_hold", result, held_r);
            chk("overflow_bubble", {31'b0, overflow}, 32'b0);
        end
        prev = cur;
    endtask

    initial begin
        logic [31:0] bb;
        logic [31:0] ra;
        logic [31:0] rb;
        int          mode;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        prev     = '{v: 1'b0, r: 32'h0, o: 1'b0};
        held_r   = '0;

        #1;
        chk("reset_out_valid", {31'b0, out_valid}, 32'b0);
        chk("reset_result", result, 32'h0);
        chk("reset_overflow", {31'b0, overflow}, 32'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 1.0 * 1.0
        step(1, 32'h40000000, 32'h40000000);
        step(0, 32'h0, 32'h0);
        chk("t1_one_times_one", result, 32'h40000000);
        chk("t1_overflow", {31'b0, overflow}, 32'b0);

        // -1.5 * 1.25
        step(1, 32'hA0000000, 32'h50000000);
        step(0, 32'h0, 32'h0);
        chk("t2_neg_product", result, 32'h88000000);

        // -1.5 * -1.5 = 2.25 overflows
        step(1, 32'hA0000000, 32'hA0000000);
        step(0, 32'h0, 32'h0);
        chk("t3_overflow_flag", {31'b0, overflow}, 32'b1);
`ifdef FIXED32_MUL_SAT_EN
        chk("t3_overflow_result", result, 32'h7FFFFFFF);
`else
        chk("t3_overflow_result", result, 32'h90000000);
`endif
        step(0, 32'h0, 32'h0);

        // -2.0 * -2.0 = +4.0 overflows
        step(1, 32'h80000000, 32'h80000000);
        step(0, 32'h0, 32'h0);
        chk("t3b_min_times_min_ovf", {31'b0, overflow}, 32'b1);

        // Rounding: exact half LSB rounds up, tiny product rounds to zero
        step(1, 32'h00008000, 32'h00004000);
        step(1, 32'h00000001, 32'h00000001);
        chk("t4_round_half_up", result, 32'h00000001);
        step(0, 32'h0, 32'h0);
        chk("t4_round_tiny", result, 32'h00000000);

        // Back-to-back: b halves every cycle
        bb = 32'hA0000000;
        for (int i = 0; i < 30; i++) begin
            step(1, 32'hA0000000, bb);
            bb = $signed(bb) >>> 1;
        end
        step(0, 32'h0, 32'h0);
        step(0, 32'h0, 32'h0);

        // Randomized traffic with bubbles and boundary operands
        for (int i = 0; i < 200; i++) begin
            mode = $urandom_range(0, 3);
            ra   = $urandom;
            rb   = $urandom;
            if (mode == 1) begin
                ra = 32'($signed(ra) >>> 15);
                rb = 32'($signed(rb) >>> 15);
            end else if (mode == 2) begin
                ra = ($urandom_range(0, 1) != 0) ? 32'h80000000 : 32'h7FFFFFFF;
                rb = ($urandom_range(0, 1) != 0) ? 32'h80000000 : 32'h40000000;
            end
            step($urandom_range(0, 3) != 0, ra, rb);
        end
        step(0, 32'h0, 32'h0);

        // Reset with two products in flight
        step(1, 32'h30000000, 32'h20000000);
        step(1, 32'hA0000000, 32'hA0000000);
        @(negedge clk);
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", {31'b0, out_valid}, 32'b0);
        chk("midreset_result", result, 32'h0);
        chk("midreset_overflow", {31'b0, overflow}, 32'b0);
        in_valid = 1'b0;
        prev     = '{v: 1'b0, r: 32'h0, o: 1'b0};
        held_r   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(0, 32'h7FFFFFFF, 32'h7FFFFFFF);
        end
        step(1, 32'h40000000, 32'hC0000000);
        step(0, 32'h0, 32'h0);
        chk("post_reset_product", result, 32'hC0000000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
